output_layer_argmax: RTL and testbench

Downstream stage of the hidden layer. It collects N_HIDDEN signed hidden-neuron values, one per hidden-layer `done` pulse. It then computes N_OUT dot products against signed weights held in an external synchronous ROM, and reports the index and score of the largest output neuron. Its result is the classification produced by the complete network.

---
 rtl/nn_pkg.sv | 22 ++
 rtl/signed_mac.sv | 48 ++++
 rtl/output_layer_argmax.sv | 184 ++++++++++++++++++
 tb/tb_output_layer_argmax.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the network datapath.
// Holds the default sizing of the hidden and output layers and the output-layer
// state encoding. The hidden layer uses the same DATA_W so its output_val
// connects directly to this block's in_data.
package nn_pkg;

  localparam int N_HIDDEN = 30;  // hidden values per frame
  localparam int N_OUT    = 10;  // output neurons (classes)
  localparam int DATA_W   = 20;  // hidden value width, signed
  localparam int W_W      = 8;   // weight width, signed
  localparam int ACC_W    = 34;  // accumulator / score width, signed
  localparam int ADDR_W   = 9;   // weight ROM address width
  localparam int CLS_W    = 4;   // class index width

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    MAC     = 2'd1,
    CMP     = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/signed_mac.sv
// Single signed multiply-accumulate register.
// Ports:
//   clk, rst  - clock, asynchronous active-low reset (acc -> 0)
//   clr       - synchronous clear of the accumulator (wins over en)
//   en        - add a*b to the accumulator this cycle
//   a, b      - signed operands
//   acc       - signed running sum
module signed_mac #(
  parameter int DATA_W = 20,
  parameter int W_W    = 8,
  parameter int ACC_W  = 34
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [W_W-1:0]    b,
  output logic signed [ACC_W-1:0]  acc
);

  localparam int PW = DATA_W + W_W;

  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;
  logic signed [PW-1:0] prod;
  logic signed [ACC_W-1:0] prod_ext;

  // Operands are widened to the full product width first so the multiply is
  // performed at full precision.
  always_comb begin
    a_ext    = {{W_W{a[DATA_W-1]}}, a};
    b_ext    = {{DATA_W{b[W_W-1]}}, b};
    prod     = a_ext * b_ext;
    prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod_ext;
    end
  end

endmodule

// File: rtl/output_layer_argmax.sv
// Output layer of the network with argmax classification.
// Collects N_HIDDEN signed hidden values, computes N_OUT dot products against
// weights read from an external 1-cycle-latency ROM (row-major per output
// neuron) and reports the index and score of the largest output.
//
// state   | meaning
// --------+-------------------------------------------------------------
// COLLECT | accepting hidden values into the buffer, in_ready=1
// MAC     | N_HIDDEN+1 cycles per output: address ROM, accumulate products
// CMP     | compare accumulator against best, clear accumulator, next output
// DONE    | one-cycle done pulse, new class_idx/class_score visible
//
// Ports:
//   clk, rst      - clock, asynchronous active-low reset
//   in_valid      - hidden value strobe (hidden-layer done)
//   in_data       - hidden value (hidden-layer output_val)
//   in_ready      - high while collecting
//   w_addr        - weight ROM address
//   w_data        - weight ROM data, valid the cycle after w_addr
//   class_idx     - winning output neuron
//   class_score   - winning accumulator value
//   done          - one-cycle pulse when class_idx/class_score update
//   overrun       - sticky: in_valid seen while in_ready=0
module output_layer_argmax
  import nn_pkg::*;
#(
  parameter int N_HIDDEN = nn_pkg::N_HIDDEN,
  parameter int N_OUT    = nn_pkg::N_OUT,
  parameter int DATA_W   = nn_pkg::DATA_W,
  parameter int W_W      = nn_pkg::W_W,
  parameter int ACC_W    = nn_pkg::ACC_W,
  parameter int ADDR_W   = nn_pkg::ADDR_W,
  parameter int CLS_W    = nn_pkg::CLS_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  output logic [ADDR_W-1:0]        w_addr,
  input  logic signed [W_W-1:0]    w_data,
  output logic [CLS_W-1:0]         class_idx,
  output logic signed [ACC_W-1:0]  class_score,
  output logic                     done,
  output logic                     overrun
);

  localparam int KW = $clog2(N_HIDDEN + 1);
  localparam int IW = (N_HIDDEN > 1) ? $clog2(N_HIDDEN) : 1;

  state_t state, next_state;

  logic signed [DATA_W-1:0] hid_buf [N_HIDDEN];
  logic [KW-1:0]            cnt;
  logic [KW-1:0]            k_cnt;
  logic [CLS_W-1:0]         o_cnt;
  logic signed [ACC_W-1:0]  best;
  logic [CLS_W-1:0]         best_idx;
  logic signed [ACC_W-1:0]  mac_acc;

  logic          mac_en;
  logic          mac_clr;
  logic          accept;
  logic          last_in;
  logic          last_out;
  logic          take_new;
  logic [IW-1:0] rd_idx;

  // Product for cycle k uses buffer entry k-1: the ROM word addressed in
  // cycle k-1 arrives in cycle k.
  assign rd_idx   = IW'(k_cnt - 1'b1);
  assign accept   = in_valid && (state == COLLECT);
  assign last_in  = (cnt == KW'(N_HIDDEN - 1));
  assign last_out = (o_cnt == CLS_W'(N_OUT - 1));
  // Strictly greater keeps the lower index on ties.
  assign take_new = (o_cnt == '0) || (mac_acc > best);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= COLLECT;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    done       = 1'b0;
    mac_en     = 1'b0;
    mac_clr    = 1'b0;
    case (state)
      COLLECT: begin
        in_ready = 1'b1;
        if (in_valid && last_in) next_state = MAC;
      end
      MAC: begin
        mac_en = (k_cnt != '0);
        if (k_cnt == KW'(N_HIDDEN)) next_state = CMP;
      end
      CMP: begin
        mac_clr    = 1'b1;
        next_state = last_out ? DONE : MAC;
      end
      DONE: begin
        done       = 1'b1;
        next_state = COLLECT;
      end
      default: next_state = COLLECT;
    endcase
  end

  // Hidden buffer needs no reset: entries are always written before use.
  always_ff @(posedge clk) begin
    if (accept) hid_buf[IW'(cnt)] <= in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      k_cnt       <= '0;
      o_cnt       <= '0;
      w_addr      <= '0;
      best        <= '0;
      best_idx    <= '0;
      class_idx   <= '0;
      class_score <= '0;
      overrun     <= 1'b0;
    end else begin
      if (in_valid && !in_ready) overrun <= 1'b1;
      case (state)
        COLLECT: begin
          if (in_valid) begin
            if (last_in) begin
              cnt    <= '0;
              k_cnt  <= '0;
              o_cnt  <= '0;
              w_addr <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        MAC: begin
          k_cnt <= k_cnt + 1'b1;
          // Address stops on the last weight of the row during the final
          // accumulate cycle; the next row starts at the following address.
          if (k_cnt < KW'(N_HIDDEN - 1)) w_addr <= w_addr + 1'b1;
        end
        CMP: begin
          if (take_new) begin
            best     <= mac_acc;
            best_idx <= o_cnt;
          end
          if (last_out) begin
            // Publish on entry to DONE so outputs are valid alongside done.
            class_idx   <= take_new ? o_cnt : best_idx;
            class_score <= take_new ? mac_acc : best;
          end else begin
            o_cnt  <= o_cnt + 1'b1;
            k_cnt  <= '0;
            w_addr <= w_addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  signed_mac #(
    .DATA_W (DATA_W),
    .W_W    (W_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (mac_clr),
    .en  (mac_en),
    .a   (hid_buf[rd_idx]),
    .b   (w_data),
    .acc (mac_acc)
  );

endmodule

// File: tb/tb_output_layer_argmax.sv
// Self-checking bench for output_layer_argmax (N_HIDDEN=4, N_OUT=3).
// A frame-level model computes scores and the argmax with plain loops and
// predicts the done cycle; a negedge process compares every cycle.
module tb_output_layer_argmax;

  localparam int NH = 4;
  localparam int NO = 3;
  localparam int DW = 20;
  localparam int WW = 8;
  localparam int AW = 34;
  localparam int ADW = 9;
  localparam int CW = 4;
  localparam int LAT = NO * (NH + 2) + 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic signed [DW-1:0] in_data;
  logic                 in_ready;
  logic [ADW-1:0]       w_addr;
  logic signed [WW-1:0] w_data;
  logic [CW-1:0]        class_idx;
  logic signed [AW-1:0] class_score;
  logic                 done;
  logic                 overrun;

  output_layer_argmax #(
    .N_HIDDEN (NH), .N_OUT (NO), .DATA_W (DW), .W_W (WW),
    .ACC_W (AW), .ADDR_W (ADW), .CLS_W (CW)
  ) dut (
    .clk (clk), .rst (rst), .in_valid (in_valid), .in_data (in_data),
    .in_ready (in_ready), .w_addr (w_addr), .w_data (w_data),
    .class_idx (class_idx), .class_score (class_score),
    .done (done), .overrun (overrun)
  );

  always #5 clk = ~clk;

  logic signed [WW-1:0] rom [0:511];
  always @(posedge clk) w_data <= rom[w_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model state
  int      hid [NH];
  int      acc_cyc = -1;
  int      done_cyc = -1;
  int      pend_idx, pend_score;
  longint  exp_score = 0;
  int      exp_idx = 0;
  bit      exp_overrun = 1'b0;
  bit      chk_en = 1'b0;

  task automatic model_reset();
    done_cyc    = -1;
    acc_cyc     = -1;
    exp_idx     = 0;
    exp_score   = 0;
    exp_overrun = 1'b0;
  endtask

  task automatic set_rows(input int r0, input int r1, input int r2);
    for (int i = 0; i < 512; i++) rom[i] = '0;
    for (int k = 0; k < NH; k++) begin
      rom[0*NH+k] = WW'(r0);
      rom[1*NH+k] = WW'(r1);
      rom[2*NH+k] = WW'(r2);
    end
  endtask

  task automatic set_hid(input int a, input int b, input int c, input int d);
    hid[0] = a; hid[1] = b; hid[2] = c; hid[3] = d;
  endtask

  // Frame model: dot products, then argmax with strict compare.
  task automatic model_frame();
    longint s, best;
    int bi;
    best = 0;
    bi = 0;
    for (int o = 0; o < NO; o++) begin
      s = 0;
      for (int k = 0; k < NH; k++) s += longint'(hid[k]) * longint'(rom[o*NH+k]);
      if (o == 0 || s > best) begin
        best = s;
        bi = o;
      end
    end
    pend_idx   = bi;
    pend_score = int'(best);
  endtask

  task automatic send_frame();
    for (int i = 0; i < NH; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(hid[i]);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    model_frame();
    acc_cyc  = cyc;
    done_cyc = cyc + LAT - 1;
  endtask

  task automatic wait_result();
    repeat (LAT + 2) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    bit busy, exp_done;
    if (chk_en) begin
      exp_done = (done_cyc >= 0) && (cyc == done_cyc);
      if (exp_done) begin
        exp_idx   = pend_idx;
        exp_score = pend_score;
      end
      busy = (done_cyc >= 0) && (cyc >= acc_cyc) && (cyc <= done_cyc);
      chk("in_ready", in_ready, !busy);
      chk("done", done, exp_done);
      chk("class_idx", class_idx, exp_idx);
      chk("class_score", class_score, exp_score);
      chk("overrun", overrun, exp_overrun);
    end
  end

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    set_rows(0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    chk_en = 1'b1;

    // 1. reset mid-idle
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_class_idx", class_idx, 0);
    chk("rst_class_score", class_score, 0);
    chk("rst_w_addr", w_addr, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // 2. basic classification
    set_rows(1, 2, -1);
    set_hid(1, 2, 3, 4);
    send_frame();
    chk("model_s2_idx", pend_idx, 1);
    chk("model_s2_score", pend_score, 20);
    wait_result();
    chk("s2_class_idx", class_idx, 1);
    chk("s2_class_score", class_score, 20);

    // 3a. negative inputs, winner +4
    set_rows(1, -1, 1);
    set_hid(-1, -1, -1, -1);
    send_frame();
    chk("model_s3a_score", pend_score, 4);
    wait_result();
    chk("s3a_class_idx", class_idx, 1);
    chk("s3a_class_score", class_score, 4);

    // 3b. three-way tie at -4 keeps index 0
    set_rows(1, 1, 1);
    send_frame();
    wait_result();
    chk("s3b_class_idx", class_idx, 0);
    chk("s3b_class_score", class_score, -4);

    // 4. extremes
    set_rows(-128, 0, 0);
    set_hid(-524288, -524288, -524288, -524288);
    send_frame();
    chk("model_s4_score", pend_score, 268435456);
    wait_result();
    chk("s4_class_idx", class_idx, 0);
    chk("s4_class_score", class_score, 268435456);

    // 5. overrun during MAC
    set_rows(1, 2, -1);
    set_hid(1, 2, 3, 4);
    send_frame();
    repeat (4) @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = DW'(12345);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    exp_overrun = 1'b1;
    repeat (LAT) @(posedge clk);
    #1;
    chk("s5_overrun", overrun, 1);
    chk("s5_class_idx", class_idx, 1);
    chk("s5_class_score", class_score, 20);
    set_hid(4, 3, 2, 1);
    set_rows(-1, 1, 3);
    send_frame();
    chk("model_s5b_score", pend_score, 30);
    wait_result();
    chk("s5b_class_idx", class_idx, 2);

    // 6. reset during MAC of output 1
    set_rows(1, 2, -1);
    set_hid(1, 2, 3, 4);
    send_frame();
    repeat (NH + 4) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("s6_rst_class_idx", class_idx, 0);
    chk("s6_rst_overrun", overrun, 0);
    chk("s6_rst_w_addr", w_addr, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    send_frame();
    wait_result();
    chk("s6_class_idx", class_idx, 1);
    chk("s6_class_score", class_score, 20);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
